fetch_region_ctrl: RTL and testbench

Parametrised instruction-fetch region controller for the MIPS150 fetch stage. Decodes the top PC tag bits against NUM_REGIONS programmable region tags and drives one read enable per instruction source (IMEM/icache, BIOS, external slow memory, ...). Registers the fetch-data mux select so it lines up with synchronous memory read data. Adds a ready handshake for wait-state regions, illegal-address fault reporting and a wait-cycle performance counter.

---
 rtl/fetch_region_ctrl.sv | 86 ++++++++
 tb/tb_fetch_region_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_region_ctrl.sv
// fetch_region_ctrl: PC-tag region decode, per-source read enables, wait-state handshake, fault capture
module fetch_region_ctrl #(
    parameter int ADDR_W = 32,
    parameter int TAG_W = 4,
    parameter int NUM_REGIONS = 4,
    parameter int SEL_W = 2,
    parameter logic [TAG_W*NUM_REGIONS-1:0] REGION_TAGS = {4'hC, 4'h8, 4'h4, 4'h1},
    parameter logic [NUM_REGIONS-1:0] WAIT_MASK = 4'b1100,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      pc,
    input  logic                   pc_valid,
    input  logic                   stall,
    input  logic [NUM_REGIONS-1:0] mem_ready,
    output logic [NUM_REGIONS-1:0] re,
    output logic [SEL_W-1:0]       if_sel,
    output logic                   fetch_stall,
    output logic                   fault,
    output logic                   fault_sticky,
    input  logic                   fault_clr,
    output logic [ADDR_W-1:0]      fault_pc,
    output logic [CNT_W-1:0]       wait_cnt
);
    typedef enum logic {ISSUE, WAIT} state_t;
    state_t state_q, state_d;
    logic [TAG_W-1:0] tag;
    logic [SEL_W-1:0] win, pend;
    logic legal, accept, ready;
    assign tag = pc[ADDR_W-1 -: TAG_W];
    assign ready = mem_ready[pend];
    // tag decode, scanning downward so the lowest matching region wins
    always_comb begin
        legal = 1'b0;
        win = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (tag == REGION_TAGS[i*TAG_W +: TAG_W]) begin
                legal = 1'b1;
                win = SEL_W'(i);
            end
    end
    // next state and read enables; outputs are forced quiet while reset is held
    always_comb begin
        state_d = state_q;
        re = '0;
        fetch_stall = 1'b0;
        accept = 1'b0;
        if (state_q == ISSUE) begin
            accept = pc_valid && !stall;
            if (accept && legal) begin
                re[win] = 1'b1;
                if (WAIT_MASK[win]) state_d = WAIT;
            end
        end else begin
            re[pend] = 1'b1;
            fetch_stall = !ready;
            if (ready) state_d = ISSUE;
        end
        if (!reset) begin
            re = '0;
            fetch_stall = 1'b0;
        end
    end
    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= ISSUE;
        else state_q <= state_d;
    // mux select, pending region, fault capture and wait-cycle counter
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            if_sel <= '0;
            pend <= '0;
            fault <= 1'b0;
            fault_sticky <= 1'b0;
            fault_pc <= '0;
            wait_cnt <= '0;
        end else begin
            fault <= accept && !legal;
            fault_sticky <= (accept && !legal) ? 1'b1 : fault_clr ? 1'b0 : fault_sticky;
            if (accept && !legal) fault_pc <= pc;
            if (accept && legal) if_sel <= win;
            if (accept && legal && WAIT_MASK[win]) pend <= win;
            if (state_q == WAIT && !ready && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        end
endmodule

// File: tb/tb_fetch_region_ctrl.sv
// tb_fetch_region_ctrl: directed checks of region decode, wait handshake, faults and reset
module tb_fetch_region_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] pc;
    logic pc_valid, stall, fault_clr;
    logic [3:0] mem_ready;
    logic [3:0] re, re4;
    logic [1:0] if_sel, if_sel4;
    logic fetch_stall, fault, fault_sticky, fetch_stall4, fault4, fault_sticky4;
    logic [31:0] fault_pc, fault_pc4;
    logic [15:0] wait_cnt;
    logic [3:0] wait_cnt4;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_region_ctrl dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .stall(stall),
        .mem_ready(mem_ready), .re(re), .if_sel(if_sel), .fetch_stall(fetch_stall),
        .fault(fault), .fault_sticky(fault_sticky), .fault_clr(fault_clr),
        .fault_pc(fault_pc), .wait_cnt(wait_cnt)
    );

    fetch_region_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .stall(stall),
        .mem_ready(mem_ready), .re(re4), .if_sel(if_sel4), .fetch_stall(fetch_stall4),
        .fault(fault4), .fault_sticky(fault_sticky4), .fault_clr(fault_clr),
        .fault_pc(fault_pc4), .wait_cnt(wait_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        pc = 32'h1000_0000;
        pc_valid = 1'b1;
        stall = 1'b0;
        mem_ready = 4'b0000;
        fault_clr = 1'b0;
        #3;
        chk("rst_re", re, 4'b0000);
        chk("rst_fstall", fetch_stall, 1'b0);
        chk("rst_if_sel", if_sel, 2'd0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_sticky", fault_sticky, 1'b0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_wait_cnt", wait_cnt, 16'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("imem_re", re, 4'b0001);
        chk("imem_fstall", fetch_stall, 1'b0);
        cyc();
        chk("imem_if_sel", if_sel, 2'd0);
        pc = 32'h4000_0010;
        #1 chk("bios_re", re, 4'b0010);
        cyc();
        chk("bios_if_sel", if_sel, 2'd1);
        stall = 1'b1;
        pc = 32'h1000_0000;
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_re", re, 4'b0000);
            cyc();
            chk("stall_if_sel", if_sel, 2'd1);
        end
        stall = 1'b0;
        #1 chk("unstall_re", re, 4'b0001);
        cyc();
        chk("unstall_if_sel", if_sel, 2'd0);
        pc = 32'h8000_0000;
        #1 chk("ext_re_issue", re, 4'b0100);
        chk("ext_fstall_issue", fetch_stall, 1'b0);
        cyc();
        chk("ext_if_sel", if_sel, 2'd2);
        pc = 32'h1000_0000;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3) ? 4'b1011 : 4'b0000;
            #1 chk("wait_re", re, 4'b0100);
            chk("wait_fstall", fetch_stall, 1'b1);
            cyc();
        end
        mem_ready = 4'b0100;
        #1 chk("ready_fstall", fetch_stall, 1'b0);
        chk("ready_re", re, 4'b0100);
        chk("wait_cnt_4", wait_cnt, 16'd4);
        cyc();
        mem_ready = 4'b0000;
        pc = 32'h4000_0000;
        #1 chk("post_wait_re", re, 4'b0010);
        chk("post_wait_cnt", wait_cnt, 16'd4);
        cyc();
        chk("post_wait_if_sel", if_sel, 2'd1);
        pc = 32'h2000_0000;
        #1 chk("illegal_re", re, 4'b0000);
        cyc();
        chk("fault_pulse", fault, 1'b1);
        chk("fault_sticky", fault_sticky, 1'b1);
        chk("fault_pc", fault_pc, 32'h2000_0000);
        chk("fault_if_sel", if_sel, 2'd1);
        pc_valid = 1'b0;
        cyc();
        chk("fault_pulse_end", fault, 1'b0);
        chk("sticky_hold", fault_sticky, 1'b1);
        pc_valid = 1'b1;
        pc = 32'h3000_0004;
        fault_clr = 1'b1;
        cyc();
        chk("set_wins", fault_sticky, 1'b1);
        chk("fault_pc2", fault_pc, 32'h3000_0004);
        pc_valid = 1'b0;
        cyc();
        chk("sticky_clr", fault_sticky, 1'b0);
        chk("fault_after_clr", fault, 1'b0);
        fault_clr = 1'b0;
        pc_valid = 1'b1;
        pc = 32'hC000_0000;
        #1 chk("r3_re", re, 4'b1000);
        cyc();
        pc_valid = 1'b0;
        cyc();
        chk("midwait_cnt", wait_cnt, 16'd5);
        chk("midwait_re", re, 4'b1000);
        chk("midwait_fstall", fetch_stall, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_re", re, 4'b0000);
        chk("async_fstall", fetch_stall, 1'b0);
        chk("async_if_sel", if_sel, 2'd0);
        chk("async_wait_cnt", wait_cnt, 16'd0);
        cyc();
        reset = 1'b1;
        #1 chk("after_rst_re", re, 4'b0000);
        cyc();
        pc_valid = 1'b1;
        pc = 32'h8000_0000;
        cyc();
        pc_valid = 1'b0;
        for (int k = 0; k < 20; k++) cyc();
        chk("sat_cnt4", wait_cnt4, 4'd15);
        chk("sat_cnt16", wait_cnt, 16'd20);
        chk("sat_fstall", fetch_stall4, 1'b1);
        mem_ready = 4'b0100;
        cyc();
        mem_ready = 4'b0000;
        #1 chk("sat_done_fstall", fetch_stall, 1'b0);
        chk("sat_done_re", re, 4'b0000);
        chk("sat_hold_cnt4", wait_cnt4, 4'd15);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
